// File: rtl/demux1x4_stream.sv
// demux1x4_stream: registered 1-to-4 stream demultiplexer.
// Each accepted input word is steered to one of four single-word output
// buffers using the mux4x1 select encoding (11->1, 01->2, 10->3, 00->4).
// Every port keeps a saturating count of words drained by its sink.
module demux1x4_stream #(
    parameter int unsigned data_width = 8,
    parameter int unsigned cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_sel,
    input  logic [data_width-1:0] in_data,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [data_width-1:0] out_data1,
    output logic [data_width-1:0] out_data2,
    output logic [data_width-1:0] out_data3,
    output logic [data_width-1:0] out_data4,
    output logic [cnt_width-1:0]  out_cnt1,
    output logic [cnt_width-1:0]  out_cnt2,
    output logic [cnt_width-1:0]  out_cnt3,
    output logic [cnt_width-1:0]  out_cnt4
);

    // Per-port occupancy state; the state bit is exported directly as out_valid.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [3:0]            state_q;
    logic [3:0]            state_d;
    logic [data_width-1:0] data_q [4];
    logic [data_width-1:0] data_d [4];
    logic [cnt_width-1:0]  cnt_q  [4];
    logic [cnt_width-1:0]  cnt_d  [4];

    logic [1:0] port_idx;
    logic       accept;
    logic [3:0] load;
    logic [3:0] drain;

    // Decode the select into a zero-based port index (port 1 -> index 0).
    always_comb begin
        port_idx = 2'd3;
        case (in_sel)
            2'b11:   port_idx = 2'd0;
            2'b01:   port_idx = 2'd1;
            2'b10:   port_idx = 2'd2;
            default: port_idx = 2'd3;
        endcase
    end

    // Ready depends only on the selected port's state and its sink; never on in_valid.
    always_comb begin
        in_ready = (state_q[port_idx] == ST_EMPTY) | out_ready[port_idx];
        accept   = in_valid & in_ready;
    end

    // Per-port next state: load on accept, clear on drain without load, count drains.
    always_comb begin
        load    = '0;
        drain   = '0;
        state_d = state_q;
        for (int unsigned j = 0; j < 4; j++) begin
            data_d[j] = data_q[j];
            cnt_d[j]  = cnt_q[j];
            load[j]   = accept & (port_idx == 2'(j));
            drain[j]  = (state_q[j] == ST_FULL) & out_ready[j];
            case (state_q[j])
                ST_EMPTY: if (load[j]) state_d[j] = ST_FULL;
                default:  if (drain[j] && !load[j]) state_d[j] = ST_EMPTY;
            endcase
            if (load[j]) begin
                data_d[j] = in_data;
            end
            if (drain[j] && (cnt_q[j] != '1)) begin
                cnt_d[j] = cnt_q[j] + cnt_width'(1);
            end
        end
    end

    // State, buffer and counter registers; reset empties every port immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            for (int unsigned j = 0; j < 4; j++) begin
                data_q[j] <= '0;
                cnt_q[j]  <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int unsigned j = 0; j < 4; j++) begin
                data_q[j] <= data_d[j];
                cnt_q[j]  <= cnt_d[j];
            end
        end
    end

    // Output mapping.
    always_comb begin
        out_valid = state_q;
        out_data1 = data_q[0];
        out_data2 = data_q[1];
        out_data3 = data_q[2];
        out_data4 = data_q[3];
        out_cnt1  = cnt_q[0];
        out_cnt2  = cnt_q[1];
        out_cnt3  = cnt_q[2];
        out_cnt4  = cnt_q[3];
    end

endmodule

// File: tb/tb_demux1x4_stream.sv
// Directed testbench for demux1x4_stream: routing, mux recombination,
// backpressure, cross-port independence, async reset, streaming, saturation.
module tb_demux1x4_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sel;
    logic [7:0] in_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data1, out_data2, out_data3, out_data4;
    logic [7:0] out_cnt1, out_cnt2, out_cnt3, out_cnt4;

    // Second instance with narrow counters for the saturation check.
    logic       s_in_valid;
    logic       s_in_ready;
    logic [1:0] s_in_sel;
    logic [7:0] s_in_data;
    logic [3:0] s_out_valid;
    logic [3:0] s_out_ready;
    logic [7:0] s_d1, s_d2, s_d3, s_d4;
    logic [3:0] s_c1, s_c2, s_c3, s_c4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux1x4_stream #(.data_width(8), .cnt_width(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3), .out_data4(out_data4),
        .out_cnt1(out_cnt1), .out_cnt2(out_cnt2), .out_cnt3(out_cnt3), .out_cnt4(out_cnt4)
    );

    demux1x4_stream #(.data_width(8), .cnt_width(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sel(s_in_sel), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data1(s_d1), .out_data2(s_d2), .out_data3(s_d3), .out_data4(s_d4),
        .out_cnt1(s_c1), .out_cnt2(s_c2), .out_cnt3(s_c3), .out_cnt4(s_c4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference 4:1 select mux with the shared encoding.
    function automatic logic [7:0] mux4(input logic [1:0] s, input logic [7:0] d1,
                                        input logic [7:0] d2, input logic [7:0] d3,
                                        input logic [7:0] d4);
        case (s)
            2'b11:   return d1;
            2'b01:   return d2;
            2'b10:   return d3;
            default: return d4;
        endcase
    endfunction

    logic [7:0] rt_data [4];
    logic [1:0] rt_sel  [4];
    logic [3:0] rt_vld  [4];

    initial begin
        rt_data[0] = 8'hA1; rt_sel[0] = 2'b11; rt_vld[0] = 4'b0001;
        rt_data[1] = 8'hA2; rt_sel[1] = 2'b01; rt_vld[1] = 4'b0010;
        rt_data[2] = 8'hA3; rt_sel[2] = 2'b10; rt_vld[2] = 4'b0100;
        rt_data[3] = 8'hA4; rt_sel[3] = 2'b00; rt_vld[3] = 4'b1000;

        rst_n = 1'b0;
        in_valid = 1'b0; in_sel = 2'b00; in_data = 8'h00; out_ready = 4'b0000;
        s_in_valid = 1'b0; s_in_sel = 2'b11; s_in_data = 8'h00; s_out_ready = 4'b0001;
        #2;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
        check("rst_data1", 32'(out_data1), 32'h0);
        check("rst_cnt4", 32'(out_cnt4), 32'h0);
        #10 rst_n = 1'b1;

        // Routing with all sinks ready, plus recombination through the 4:1 mux.
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = rt_sel[i]; in_data = rt_data[i];
            step();
            check("route_valid", 32'(out_valid), 32'(rt_vld[i]));
            check("route_mux", 32'(mux4(rt_sel[i], out_data1, out_data2, out_data3, out_data4)),
                  32'(rt_data[i]));
        end
        in_valid = 1'b0;
        step();
        check("route_d1", 32'(out_data1), 32'hA1);
        check("route_d2", 32'(out_data2), 32'hA2);
        check("route_d3", 32'(out_data3), 32'hA3);
        check("route_d4", 32'(out_data4), 32'hA4);
        check("route_cnt1", 32'(out_cnt1), 32'h1);
        check("route_cnt2", 32'(out_cnt2), 32'h1);
        check("route_cnt3", 32'(out_cnt3), 32'h1);
        check("route_cnt4", 32'(out_cnt4), 32'h1);
        check("route_empty", 32'(out_valid), 32'h0);

        // Backpressure on port 3.
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'b10; in_data = 8'h10;
        #1 check("bp_ready1", 32'(in_ready), 32'h1);
        step();
        check("bp_d3_first", 32'(out_data3), 32'h10);
        in_data = 8'h11;
        #1 check("bp_blocked", 32'(in_ready), 32'h0);
        step();
        check("bp_held", 32'(out_data3), 32'h10);
        check("bp_valid_held", 32'(out_valid), 32'b0100);
        out_ready = 4'b0100;
        #1 check("bp_ready2", 32'(in_ready), 32'h1);
        step();
        check("bp_swap_valid", 32'(out_valid), 32'b0100);
        check("bp_swap_data", 32'(out_data3), 32'h11);
        check("bp_cnt3", 32'(out_cnt3), 32'h2);

        // Port 3 still full and stalled: reselecting an empty port must raise ready.
        out_ready = 4'b0000;
        in_sel = 2'b11; in_data = 8'h77;
        #1 check("resel_ready", 32'(in_ready), 32'h1);
        step();
        check("nb_d1", 32'(out_data1), 32'h77);
        in_sel = 2'b00; in_data = 8'h55;
        #1 check("nb_ready", 32'(in_ready), 32'h1);
        step();
        check("nb_valid", 32'(out_valid), 32'b1101);
        check("nb_d4", 32'(out_data4), 32'h55);
        check("nb_d1_kept", 32'(out_data1), 32'h77);
        check("nb_d3_kept", 32'(out_data3), 32'h11);
        in_valid = 1'b0;
        out_ready = 4'b1111;
        step();
        check("nb_drained", 32'(out_valid), 32'h0);
        check("nb_cnt1", 32'(out_cnt1), 32'h2);
        check("nb_cnt3", 32'(out_cnt3), 32'h3);
        check("nb_cnt4", 32'(out_cnt4), 32'h2);

        // Asynchronous reset mid-cycle with port 2 full.
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'b01; in_data = 8'h3C;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_cnt2", 32'(out_cnt2), 32'h0);
        check("arst_data2", 32'(out_data2), 32'h0);
        check("arst_ready", 32'(in_ready), 32'h1);
        #3 rst_n = 1'b1;

        // Back-to-back streaming to port 2.
        out_ready = 4'b0010;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_sel = 2'b01; in_data = 8'(i + 8'h20);
            #1 check("stream_ready", 32'(in_ready), 32'h1);
            step();
            check("stream_data", 32'(out_data2), 32'(8'(i + 8'h20)));
        end
        in_valid = 1'b0;
        step();
        check("stream_cnt2", 32'(out_cnt2), 32'd100);
        check("stream_empty", 32'(out_valid), 32'h0);

        // Saturation on the narrow-counter instance.
        for (int i = 0; i < 20; i++) begin
            s_in_valid = 1'b1; s_in_data = 8'(i);
            step();
            if (i == 14) check("sat_cnt14", 32'(s_c1), 32'd14);
        end
        s_in_valid = 1'b0;
        step();
        check("sat_cnt1", 32'(s_c1), 32'd15);
        step();
        check("sat_hold", 32'(s_c1), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
